req_priority_arbiter: RTL and testbench
=======================================

// Module: req_priority_arbiter
// PURPOSE
//  Sequential fixed-priority arbiter sharing one resource among NREQ requesters.
//  Highest-index active request wins, the same priority order as our 8:3 priority encoder.
//  Holds a grant until the owner drops its request or a hold limit expires.
//  A requester that times out is masked until it releases its request, so it cannot starve the others.
//  Sits between requester blocks and the shared datapath; GNT_ID drives the datapath select.
// PARAMETERS
//  NREQ      8    number of requesters (2..8)
//  IDW       3    width of GNT_ID, must equal clog2(NREQ)
//  MAX_HOLD  16   maximum consecutive grant cycles per owner (>=1)
// PORTS
//  CLK        input   1      rising-edge clock
//  RST_N      input   1      asynchronous active-low reset
//  EN         input   1      1 = new grants allowed; 0 = finish current grant, issue no new one
//  REQ        input   NREQ   request per requester, level, held until served
//  GNT        output  NREQ   one-hot grant (all zero when idle)
//  GNT_ID     output  IDW    index of current owner, 0 when GNT_VALID=0
//  GNT_VALID  output  1      1 while any grant is held
//  TIMEOUT    output  1      one-cycle pulse when a grant is revoked at MAX_HOLD
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE, GNT=0, GNT_ID=0, GNT_VALID=0, TIMEOUT=0, hold_cnt=0, MASK=0.
//  All outputs are registered. No combinational path from REQ to GNT.
//  Eligible set: E = REQ & ~MASK. Winner = highest set index of E.
//  States: IDLE, GRANT, GAP.
//   IDLE:  if EN && E!=0, next state is GRANT. GNT/GNT_ID/GNT_VALID take the winner on that edge.
//          Latency is 1 cycle from REQ sampled high to GNT high. hold_cnt is loaded with 1.
//   GRANT: if REQ[owner]==0, go to GAP. Outputs clear at that edge; normal release.
//          Else if hold_cnt==MAX_HOLD: go to GAP, clear outputs, set MASK[owner], pulse TIMEOUT for 1 cycle.
//          Else stay in GRANT and increment hold_cnt.
//          A higher-priority request arriving mid-grant does NOT pre-empt.
//   GAP:   one idle cycle with GNT=0, then go to IDLE. This guarantees a dead cycle between owners.
//  MASK[i] clears on any cycle REQ[i]==0. MASK[i] is never set except by a timeout.
//  Resulting grant count per owner is MAX_HOLD cycles maximum.
//  Re-grant latency after release is at least 2 cycles (GAP, then IDLE evaluation).
//  EN=0 affects only the IDLE->GRANT decision; a running grant is unaffected.
//  All REQ masked (E=0) with REQ!=0: stay IDLE until a mask clears.
//  REQ bits at or above NREQ do not exist; GNT is always one-hot or zero, never multi-hot.
//  Simultaneous release and timeout (REQ[owner]=0 at hold_cnt==MAX_HOLD): treated as release.
//   No TIMEOUT pulse, no MASK set.
//  RST_N asserted mid-grant: outputs drop immediately (async). First grant after release follows IDLE rules.
// TESTING
//  1. Reset, REQ=8'h00 for 5 cycles -> GNT=0, GNT_VALID=0, GNT_ID=0, TIMEOUT=0 throughout.
//  2. REQ=8'b0010_0110 at cycle 0 -> cycle 1 GNT=8'h20, GNT_ID=5; drop REQ[5] -> next edge GNT=0;
//     one GAP cycle; then GNT=8'h04, GNT_ID=2.
//  3. REQ[3] held forever, MAX_HOLD=16 -> GNT[3] high exactly 16 cycles, TIMEOUT 1-cycle pulse, GAP;
//     no re-grant to 3 until REQ[3] low for 1 cycle.
//  4. REQ[7] and REQ[0] held, MAX_HOLD=4 -> grants alternate 7 (4 cycles), 0 after mask;
//     7 re-granted only after it toggles low.
//  5. Grant to 2 active, raise REQ[6] -> GNT stays 8'h04 until REQ[2] drops (no pre-emption).
//  6. EN=0 with REQ=8'h10 -> no grant; EN=1 -> GNT=8'h10 next edge.
//     RST_N low mid-grant -> GNT=0 asynchronously.

Source files
------------

// File: rtl/req_priority_arbiter.sv
// req_priority_arbiter
// Sequential fixed-priority arbiter. The highest-index eligible requester wins.
// A grant is held until the owner releases its request or the hold limit expires.
// An owner that times out is masked until it drops its request, so it cannot starve the others.
// A dead GAP cycle always separates two owners.
// All outputs are registered; there is no combinational path from req to gnt.

module req_priority_arbiter #(
    parameter int NREQ     = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   hold_cnt;
    logic [CW-1:0]   hold_cnt_nxt;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] mask_nxt;
    logic [NREQ-1:0] mask_set;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt_nxt;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  gnt_id_nxt;
    logic            gnt_valid_nxt;
    logic            timeout_nxt;
    logic            owner_req;

    assign elig      = req & ~mask;
    assign owner_req = req[gnt_id];

    // Highest-index eligible requester wins; later iterations override earlier ones.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (elig[i]) begin
                win_id = IDW'(i);
            end
        end
    end

    // Next-state, next-output and mask update for the IDLE/GRANT/GAP machine.
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = '0;
        gnt_id_nxt    = '0;
        gnt_valid_nxt = 1'b0;
        timeout_nxt   = 1'b0;
        hold_cnt_nxt  = '0;
        mask_set      = '0;

        case (state)
            IDLE: begin
                if (en && (elig != '0)) begin
                    state_nxt     = GRANT;
                    gnt_nxt       = NREQ'(1) << win_id;
                    gnt_id_nxt    = win_id;
                    gnt_valid_nxt = 1'b1;
                    hold_cnt_nxt  = CW'(1);
                end
            end

            GRANT: begin
                if (!owner_req) begin
                    // Normal release wins over a timeout on the same cycle.
                    state_nxt = GAP;
                end else if (hold_cnt == CW'(MAX_HOLD)) begin
                    state_nxt        = GAP;
                    timeout_nxt      = 1'b1;
                    mask_set[gnt_id] = 1'b1;
                end else begin
                    gnt_nxt       = gnt;
                    gnt_id_nxt    = gnt_id;
                    gnt_valid_nxt = 1'b1;
                    hold_cnt_nxt  = hold_cnt + CW'(1);
                end
            end

            GAP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A mask bit survives only while its request stays high.
        mask_nxt = (mask & req) | mask_set;
    end

    // Register state, counter, mask and all outputs; async reset drops everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            mask      <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            mask      <= mask_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_req_priority_arbiter.sv
// tb_req_priority_arbiter
// Directed vectors with hand-computed expectations. The stimulus pushes the
// expected outputs for each driven cycle into a queue; a monitor on the
// falling edge pops and compares them independently of the stimulus.

module tb_req_priority_arbiter;

    localparam int NREQ     = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 16;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            en    = 1'b1;
    logic [NREQ-1:0] req   = '0;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_valid;
    logic            timeout;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [IDW-1:0]  id;
        logic            valid;
        logic            to;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_x;
    string mon_name;
    int    n_checks = 0;
    int    n_fails  = 0;

    req_priority_arbiter #(
        .NREQ     (NREQ),
        .IDW      (IDW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [NREQ-1:0] eg,
                                input logic [IDW-1:0] eid, input logic ev, input logic eto);
        n_checks++;
        if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev || timeout !== eto) begin
            n_fails++;
            $display("[TB] FAIL %s @%0t: got gnt=%h id=%0d valid=%b timeout=%b, expected gnt=%h id=%0d valid=%b timeout=%b",
                     name, $time, gnt, gnt_id, gnt_valid, timeout, eg, eid, ev, eto);
        end
    endtask

    // Drive one cycle of inputs just after a falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic apply_stimulus(input logic [NREQ-1:0] r, input logic e,
                                  input logic [NREQ-1:0] eg, input logic [IDW-1:0] eid,
                                  input logic ev, input logic eto, input string name);
        exp_t x;
        @(negedge clk);
        #1;
        req     = r;
        en      = e;
        x.gnt   = eg;
        x.id    = eid;
        x.valid = ev;
        x.to    = eto;
        exp_q.push_back(x);
        name_q.push_back(name);
    endtask

    task automatic apply_repeat(input int n, input logic [NREQ-1:0] r, input logic e,
                                input logic [NREQ-1:0] eg, input logic [IDW-1:0] eid,
                                input logic ev, input logic eto, input string name);
        for (int k = 0; k < n; k++) begin
            apply_stimulus(r, e, eg, eid, ev, eto, name);
        end
    endtask

    // Monitor: one expectation is consumed per falling edge while any are pending.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_x    = exp_q.pop_front();
            mon_name = name_q.pop_front();
            check_output(mon_name, mon_x.gnt, mon_x.id, mon_x.valid, mon_x.to);
        end
    end

    // Hard stop in case something hangs.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting req_priority_arbiter test");

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // No requests: stays idle.
        apply_repeat(5, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t1_idle");

        // Priority: 5 wins over 2 and 1, then 2 after release, GAP and IDLE evaluation.
        apply_stimulus(8'h26, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0, "t2_grant5");
        apply_stimulus(8'h06, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t2_release5");
        apply_stimulus(8'h06, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t2_gap");
        apply_stimulus(8'h06, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0, "t2_grant2");

        // Higher-priority request mid-grant does not pre-empt.
        apply_repeat(4, 8'h46, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0, "t5_no_preempt");
        apply_stimulus(8'h40, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t5_release2");
        apply_stimulus(8'h40, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t5_gap");
        apply_stimulus(8'h40, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0, "t5_grant6");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t5_release6");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t5_gap2");

        // Hold limit: exactly MAX_HOLD grant cycles, timeout pulse, masked until released.
        apply_repeat(MAX_HOLD, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, "t3_hold3");
        apply_stimulus(8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, "t3_timeout");
        apply_stimulus(8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t3_gap");
        apply_repeat(3, 8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t3_masked");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t3_unmask");
        apply_stimulus(8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, "t3_regrant");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t3_release");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t3_gap2");

        // Release on the very cycle the limit is reached: no timeout, no mask.
        apply_stimulus(8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, "t7_grant3");
        apply_repeat(MAX_HOLD - 1, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, "t7_hold3");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t7_release_at_limit");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t7_gap");
        apply_stimulus(8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, "t7_not_masked");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t7_release");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t7_gap2");

        // Two persistent requesters: 7 times out, 0 gets served, 7 waits for its toggle.
        apply_repeat(MAX_HOLD, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0, "t4_hold7");
        apply_stimulus(8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, "t4_timeout7");
        apply_stimulus(8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t4_gap");
        apply_stimulus(8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, "t4_grant0");
        apply_repeat(2, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, "t4_hold0");
        apply_stimulus(8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t4_release0");
        apply_repeat(2, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t4_7_masked");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t4_unmask7");
        apply_stimulus(8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0, "t4_regrant7");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t4_release7");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t4_gap2");

        // Enable gates only new grants; a running grant survives en=0.
        apply_repeat(3, 8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "t6_en_low");
        apply_stimulus(8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0, "t6_en_high");
        apply_stimulus(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "t6_grant_survives_en_low");

        // Asynchronous reset mid-grant: outputs drop before the next rising edge.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_output("t6_async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0, "t6_grant_after_reset");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t6_release");
        apply_stimulus(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t6_gap");

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
